// File: rtl/line_tracker_pkg.sv
// Shared state and motor-mode encodings for the line follower; the motor stage
// decodes the same MODE_* constants.
package line_tracker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_SEARCH = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    localparam logic [1:0] MODE_STOP  = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;
    localparam logic [1:0] MODE_FWD   = 2'b11;

    // Sensor pattern {l,m,r} to steering mode; 101 and 000 keep the current mode.
    function automatic logic [1:0] target_mode(input logic [2:0] pat, input logic [1:0] cur);
        case (pat)
            3'b010, 3'b111: target_mode = MODE_FWD;
            3'b110, 3'b100: target_mode = MODE_LEFT;
            3'b011, 3'b001: target_mode = MODE_RIGHT;
            default:        target_mode = cur;
        endcase
    endfunction

endpackage

// File: rtl/line_tracker_sensor_debounce.sv
// One IR sensor: 2-flop synchronizer followed by a tick-sampled debouncer that
// flips its output after DEBOUNCE consecutive disagreeing samples.
module sensor_debounce #(
    parameter int DEBOUNCE = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic filt
);

    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] run_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            run_cnt <= '0;
            filt    <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            if (tick) begin
                if (sync_2 != filt) begin
                    if (run_cnt == CNT_W'(DEBOUNCE - 1)) begin
                        filt    <= sync_2;
                        run_cnt <= '0;
                    end else begin
                        run_cnt <= run_cnt + CNT_W'(1);
                    end
                end else begin
                    run_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/line_tracker.sv
// Line-follower decision stage: sample divider, three debounced sensors and the
// track / search / halt FSM driving the motor stage.
//   state     | meaning
//   ST_IDLE   | parked, waiting for start
//   ST_TRACK  | steering from the sensor pattern
//   ST_SEARCH | line lost, keep turning the last way while counting ticks
//   ST_HALT   | search timed out, stopped until the line reappears
module line_tracker
    import line_tracker_pkg::*;
#(
    parameter int SAMPLE_DIV   = 100_000,
    parameter int DEBOUNCE     = 3,
    parameter int LOST_TIMEOUT = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       left_signal,
    input  logic       mid_signal,
    input  logic       right_signal,
    output logic [1:0] mode,
    output logic [1:0] pre_mode,
    output logic       en_left,
    output logic       en_right,
    output logic       is_out_the_track,
    output logic [1:0] state_dbg
);

    localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int LOST_W = $clog2(LOST_TIMEOUT + 1);

    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic              filt_l;
    logic              filt_m;
    logic              filt_r;
    logic [2:0]        pattern;
    logic              line_lost;
    logic [1:0]        tgt;
    logic [LOST_W-1:0] lost_cnt;
    state_t            state;

    assign tick      = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
    assign pattern   = {filt_l, filt_m, filt_r};
    assign line_lost = (pattern == 3'b000);
    assign tgt       = target_mode(pattern, mode);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_left (
        .clk(clk), .rst(rst), .tick(tick), .raw(left_signal), .filt(filt_l)
    );
    sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_mid (
        .clk(clk), .rst(rst), .tick(tick), .raw(mid_signal), .filt(filt_m)
    );
    sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_right (
        .clk(clk), .rst(rst), .tick(tick), .raw(right_signal), .filt(filt_r)
    );

    // pre_mode follows every nonzero mode issued, so SEARCH can replay the last turn.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= ST_IDLE;
            lost_cnt         <= '0;
            mode             <= MODE_STOP;
            pre_mode         <= MODE_FWD;
            en_left          <= 1'b0;
            en_right         <= 1'b0;
            is_out_the_track <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_TRACK;
                        en_left  <= 1'b1;
                        en_right <= 1'b1;
                        mode     <= tgt;
                        if (tgt != MODE_STOP) pre_mode <= tgt;
                    end
                end
                ST_TRACK: begin
                    if (line_lost) begin
                        state    <= ST_SEARCH;
                        lost_cnt <= '0;
                        mode     <= pre_mode;
                    end else begin
                        mode <= tgt;
                        if (tgt != MODE_STOP) pre_mode <= tgt;
                    end
                end
                ST_SEARCH: begin
                    if (!line_lost) begin
                        state <= ST_TRACK;
                        mode  <= tgt;
                        if (tgt != MODE_STOP) pre_mode <= tgt;
                    end else if (lost_cnt == LOST_W'(LOST_TIMEOUT)) begin
                        state            <= ST_HALT;
                        mode             <= MODE_STOP;
                        en_left          <= 1'b0;
                        en_right         <= 1'b0;
                        is_out_the_track <= 1'b1;
                    end else if (tick) begin
                        lost_cnt <= lost_cnt + LOST_W'(1);
                    end
                end
                ST_HALT: begin
                    if (!line_lost) begin
                        state            <= ST_TRACK;
                        en_left          <= 1'b1;
                        en_right         <= 1'b1;
                        is_out_the_track <= 1'b0;
                        mode             <= tgt;
                        if (tgt != MODE_STOP) pre_mode <= tgt;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_tracker.sv
// Scoreboard bench for line_tracker: a reference model pushes expected outputs
// each edge, a monitor pops and compares on the falling edge.
module tb_line_tracker;

    localparam int SAMPLE_DIV   = 4;
    localparam int DEBOUNCE     = 3;
    localparam int LOST_TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       left_signal = 1'b0;
    logic       mid_signal = 1'b0;
    logic       right_signal = 1'b0;
    logic [1:0] mode;
    logic [1:0] pre_mode;
    logic       en_left;
    logic       en_right;
    logic       is_out_the_track;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    line_tracker #(
        .SAMPLE_DIV(SAMPLE_DIV), .DEBOUNCE(DEBOUNCE), .LOST_TIMEOUT(LOST_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .left_signal(left_signal), .mid_signal(mid_signal), .right_signal(right_signal),
        .mode(mode), .pre_mode(pre_mode), .en_left(en_left), .en_right(en_right),
        .is_out_the_track(is_out_the_track), .state_dbg(state_dbg)
    );

    // Reference model state
    logic [2:0] m_filt;
    int         m_run [3];
    logic [2:0] m_pipe [$];
    int         m_n;
    int         m_state;
    int         m_lost;
    logic [1:0] m_mode;
    logic [1:0] m_pre;
    logic       m_en;
    logic       m_out;
    logic [8:0] exp_q [$];

    function automatic logic [1:0] ref_target(input logic [2:0] p, input logic [1:0] cur);
        if (p == 3'b010 || p == 3'b111) return 2'b11;
        if (p[2] && !p[0]) return 2'b01;
        if (p[0] && !p[2]) return 2'b10;
        return cur;
    endfunction

    task automatic issue_mode(input logic [1:0] t);
        m_mode = t;
        if (t != 2'b00) m_pre = t;
    endtask

    always @(posedge clk) begin
        logic [2:0] samp;
        logic [1:0] nxt;
        bit         tick;
        if (!rst) begin
            m_filt  = 3'b000;
            m_run   = '{0, 0, 0};
            m_pipe  = {3'b000, 3'b000};
            m_n     = 0;
            m_state = 0;
            m_lost  = 0;
            m_mode  = 2'b00;
            m_pre   = 2'b11;
            m_en    = 1'b0;
            m_out   = 1'b0;
        end else begin
            tick = ((m_n % SAMPLE_DIV) == SAMPLE_DIV - 1);
            samp = m_pipe.pop_front();
            m_pipe.push_back({left_signal, mid_signal, right_signal});
            nxt = ref_target(m_filt, m_mode);
            case (m_state)
                0: if (start) begin m_state = 1; m_en = 1'b1; issue_mode(nxt); end
                1: begin
                    if (m_filt == 3'b000) begin m_state = 2; m_lost = 0; m_mode = m_pre; end
                    else issue_mode(nxt);
                end
                2: begin
                    if (m_filt != 3'b000) begin m_state = 1; issue_mode(nxt); end
                    else if (m_lost >= LOST_TIMEOUT) begin
                        m_state = 3; m_mode = 2'b00; m_en = 1'b0; m_out = 1'b1;
                    end else if (tick) m_lost++;
                end
                default: begin
                    if (m_filt != 3'b000) begin
                        m_state = 1; m_en = 1'b1; m_out = 1'b0; issue_mode(nxt);
                    end
                end
            endcase
            if (tick) begin
                for (int i = 0; i < 3; i++) begin
                    if (samp[i] != m_filt[i]) begin
                        m_run[i]++;
                        if (m_run[i] == DEBOUNCE) begin m_filt[i] = samp[i]; m_run[i] = 0; end
                    end else m_run[i] = 0;
                end
            end
            m_n++;
        end
        exp_q.push_back({m_mode, m_pre, m_en, m_en, m_out, 2'(m_state)});
    end

    always @(negedge clk) begin
        logic [8:0] act;
        logic [8:0] exp;
        act = {mode, pre_mode, en_left, en_right, is_out_the_track, state_dbg};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard t=%0t: no expected entry, actual %b", $time, act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                errors++;
                $display("FAIL scoreboard t=%0t: actual mode=%b pre=%b en=%b%b out=%b st=%0d, expected mode=%b pre=%b en=%b%b out=%b st=%0d",
                         $time, act[8:7], act[6:5], act[4], act[3], act[2], act[1:0],
                         exp[8:7], exp[6:5], exp[4], exp[3], exp[2], exp[1:0]);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_sensors(input logic [2:0] p);
        {left_signal, mid_signal, right_signal} = p;
    endtask

    task automatic wait_state(input int st, input int budget, input string name);
        int k = 0;
        while (int'(state_dbg) != st && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, int'(state_dbg), st);
    endtask

    initial begin
        set_sensors(3'b010);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (100) @(negedge clk);
        chk("idle mode", mode, 0);
        chk("idle enables", {en_left, en_right}, 0);
        chk("idle pre_mode", pre_mode, 3);
        chk("idle state", state_dbg, 0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start enables", {en_left, en_right}, 3);
        chk("start mode", mode, 3);

        set_sensors(3'b110);
        repeat (6) @(negedge clk);
        set_sensors(3'b010);
        repeat (20) @(negedge clk);
        chk("glitch mode", mode, 3);

        set_sensors(3'b110);
        repeat (16) @(negedge clk);
        chk("veer left mode", mode, 1);
        chk("veer left pre_mode", pre_mode, 1);

        set_sensors(3'b000);
        wait_state(2, 40, "search state");
        chk("search mode", mode, 1);
        chk("search enables", {en_left, en_right}, 3);

        set_sensors(3'b001);
        wait_state(1, 30, "reacquire state");
        chk("reacquire mode", mode, 2);
        chk("reacquire pre_mode", pre_mode, 2);

        set_sensors(3'b101);
        repeat (20) @(negedge clk);
        chk("hold 101 mode", mode, 2);
        chk("hold 101 state", state_dbg, 1);

        set_sensors(3'b000);
        wait_state(3, 80, "halt state");
        chk("halt mode", mode, 0);
        chk("halt enables", {en_left, en_right}, 0);
        chk("halt out flag", is_out_the_track, 1);

        set_sensors(3'b010);
        wait_state(1, 30, "unhalt state");
        chk("unhalt out flag", is_out_the_track, 0);
        chk("unhalt mode", mode, 3);

        set_sensors(3'b000);
        wait_state(2, 40, "search before reset");
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midreset mode", mode, 0);
        chk("midreset pre_mode", pre_mode, 3);
        chk("midreset enables", {en_left, en_right}, 0);
        chk("midreset out flag", is_out_the_track, 0);
        chk("midreset state", state_dbg, 0);

        repeat (120) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) set_sensors(3'b000);
            else set_sensors(3'($urandom_range(0, 7)));
            repeat ($urandom_range(1, 60)) @(negedge clk);
        end

        start = 1'b0;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
